// File: rtl/alu_seq_param.sv
// alu_seq_param: multi-cycle add/sub, signed Booth multiply and unsigned restoring divide sharing one datapath
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] in,
  input  logic [1:0]         op_codes,
  input  logic               valid,
  output logic               busy,
  output logic               ready,
  output logic [WIDTH-1:0]   o_lo,
  output logic [WIDTH-1:0]   o_hi,
  output logic               overflow,
  output logic               div_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d, m_q, m_d;
  logic q1_q, q1_d, sub_q, sub_d, ov_q, ov_d, dz_q, dz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a, op_b, addend, sum;
  logic [WIDTH:0] m_ext, booth, shl, trial;
  logic last;
  assign op_a = in[2*WIDTH-1:WIDTH];
  assign op_b = in[WIDTH-1:0];
  assign addend = sub_q ? ~m_q : m_q;
  assign sum = q_q + addend + WIDTH'(sub_q);
  // accumulator carries one guard bit so most-negative x most-negative stays exact
  assign m_ext = {m_q[WIDTH-1], m_q};
  assign booth = (q_q[0] && !q1_q) ? a_q - m_ext : (!q_q[0] && q1_q) ? a_q + m_ext : a_q;
  assign shl = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial = shl - {1'b0, m_q};
  assign last = cnt_q == CW'(WIDTH);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    q1_d = q1_q;
    sub_d = sub_q;
    ov_d = ov_q;
    dz_d = dz_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (valid) begin
        a_d = '0;
        q_d = op_a;
        m_d = op_b;
        q1_d = 1'b0;
        cnt_d = '0;
        sub_d = op_codes[0];
        ov_d = 1'b0;
        dz_d = 1'b0;
        state_d = op_codes[1] ? (op_codes[0] ? DIV : MUL) : ADDSUB;
        if (op_codes == 2'b11 && op_b == '0) begin
          a_d = {1'b0, op_a};
          q_d = '1;
          dz_d = 1'b1;
          state_d = DONE;
        end
      end
      ADDSUB: begin
        a_d = '0;
        q_d = sum;
        ov_d = (q_q[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != q_q[WIDTH-1]);
        state_d = DONE;
      end
      MUL: if (last) state_d = DONE;
      else begin
        a_d = {booth[WIDTH], booth[WIDTH:1]};
        q_d = {booth[0], q_q[WIDTH-1:1]};
        q1_d = q_q[0];
        cnt_d = cnt_q + CW'(1);
      end
      DIV: if (last) state_d = DONE;
      else begin
        a_d = trial[WIDTH] ? shl : trial;
        q_d = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
      q1_q <= 1'b0;
      sub_q <= 1'b0;
      ov_q <= 1'b0;
      dz_q <= 1'b0;
      cnt_q <= '0;
      busy <= 1'b0;
      ready <= 1'b0;
      o_lo <= '0;
      o_hi <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
      q1_q <= q1_d;
      sub_q <= sub_d;
      ov_q <= ov_d;
      dz_q <= dz_d;
      cnt_q <= cnt_d;
      busy <= state_d != IDLE || state_q == DONE;
      ready <= state_q == DONE;
      if (state_q == DONE) begin
        o_lo <= q_q;
        o_hi <= a_q[WIDTH-1:0];
        overflow <= ov_q;
        div_zero <= dz_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: 8- and 16-bit instances checked every cycle against an arithmetic reference model
module tb_alu_seq_param;
  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        ov;
    logic        dz;
  } res_t;
  logic clk = 1'b0, rst = 1'b0, valid = 1'b0;
  logic [15:0] ai = '0, bi = '0, ra, rb;
  logic [1:0] opi = '0;
  int checks = 0, errors = 0;
  int lat, pulses;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic res_t ref_calc(int w, logic [1:0] op, logic [15:0] a, logic [15:0] b);
    longint mk = (longint'(1) << w) - 1;
    longint ua = longint'(a) & mk;
    longint ub = longint'(b) & mk;
    longint sa = (ua > mk / 2) ? ua - (mk + 1) : ua;
    longint sb = (ub > mk / 2) ? ub - (mk + 1) : ub;
    longint r;
    res_t x = '0;
    case (op)
      2'd0: begin r = sa + sb; x.lo = 16'(r & mk); x.ov = r > mk / 2 || r < -(mk + 1) / 2; end
      2'd1: begin r = sa - sb; x.lo = 16'(r & mk); x.ov = r > mk / 2 || r < -(mk + 1) / 2; end
      2'd2: begin r = sa * sb; x.lo = 16'(r & mk); x.hi = 16'((r >>> w) & mk); end
      default: if (ub == 0) begin x.lo = 16'(mk); x.hi = 16'(ua); x.dz = 1'b1; end
               else begin x.lo = 16'(ua / ub); x.hi = 16'(ua % ub); end
    endcase
    return x;
  endfunction

  function automatic int ref_lat(int w, logic [1:0] op, logic [15:0] b);
    int bm = int'(b) & ((1 << w) - 1);
    return op < 2'd2 ? 2 : (op == 2'd3 && bm == 0) ? 1 : w + 2;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = g ? 16 : 8;
    logic rdy, bsy, ov, dz;
    logic [W-1:0] lo, hi;
    res_t e, p;
    logic e_rdy = 1'b0, e_bsy = 1'b0, pend = 1'b0, armed = 1'b0;
    int n = 0, due = 0;
    alu_seq_param #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in({ai[W-1:0], bi[W-1:0]}), .op_codes(opi), .valid(valid),
      .busy(bsy), .ready(rdy), .o_lo(lo), .o_hi(hi), .overflow(ov), .div_zero(dz)
    );
    always @(posedge clk) begin
      n <= n + 1;
      if (!rst) begin
        armed <= 1'b1;
        pend <= 1'b0;
        e <= '0;
        e_rdy <= 1'b0;
        e_bsy <= 1'b0;
      end else begin
        e_rdy <= pend && n == due;
        e_bsy <= pend || valid;
        if (pend && n == due) begin
          e <= p;
          pend <= 1'b0;
        end else if (!pend && valid) begin
          p <= ref_calc(W, opi, ai, bi);
          due <= n + ref_lat(W, opi, bi);
          pend <= 1'b1;
        end
      end
    end
    always @(negedge clk) if (armed) begin
      chk($sformatf("w%0d ready", W), 32'(rdy), 32'(e_rdy));
      chk($sformatf("w%0d busy", W), 32'(bsy), 32'(e_bsy));
      chk($sformatf("w%0d o_lo", W), 32'(lo), 32'(e.lo[W-1:0]));
      chk($sformatf("w%0d o_hi", W), 32'(hi), 32'(e.hi[W-1:0]));
      chk($sformatf("w%0d overflow", W), 32'(ov), 32'(e.ov));
      chk($sformatf("w%0d div_zero", W), 32'(dz), 32'(e.dz));
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((u[0].bsy || u[1].bsy) && k < 100) begin @(negedge clk); k++; end
    chk("idle wait bound", 32'(k < 100), 1);
  endtask

  task automatic go(input int sel, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                    input bit noise, output int l);
    wait_idle();
    ai = a;
    bi = b;
    opi = op;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    l = 0;
    while (!(sel != 0 ? u[1].rdy : u[0].rdy) && l < 40) begin
      if (noise) begin
        valid = 1'($urandom);
        ai = 16'($urandom);
        bi = 16'($urandom);
        opi = 2'($urandom);
      end
      @(negedge clk);
      l++;
    end
    valid = 1'b0;
    if (l >= 40) chk("ready wait bound", 32'(l), 39);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("reset o_lo", 32'(u[0].lo), 0);
    chk("reset busy", 32'(u[0].bsy), 0);
    go(0, 16'd100, 16'd50, 2'b00, 1'b0, lat);
    chk("add latency", lat, 2);
    chk("add o_lo", 32'(u[0].lo), 32'h96);
    chk("add o_hi", 32'(u[0].hi), 0);
    chk("add overflow", 32'(u[0].ov), 1);
    go(0, 16'd5, 16'd7, 2'b01, 1'b0, lat);
    chk("sub o_lo", 32'(u[0].lo), 32'hFE);
    chk("sub overflow", 32'(u[0].ov), 0);
    go(0, 16'h00FD, 16'd7, 2'b10, 1'b0, lat);
    chk("mul latency", lat, 10);
    chk("mul o_hi", 32'(u[0].hi), 32'hFF);
    chk("mul o_lo", 32'(u[0].lo), 32'hEB);
    go(0, 16'h0080, 16'h0080, 2'b10, 1'b0, lat);
    chk("mul minneg o_hi", 32'(u[0].hi), 32'h40);
    chk("mul minneg o_lo", 32'(u[0].lo), 32'h00);
    go(0, 16'd200, 16'd7, 2'b11, 1'b0, lat);
    chk("div latency", lat, 10);
    chk("div o_lo", 32'(u[0].lo), 32'h1C);
    chk("div o_hi", 32'(u[0].hi), 32'h04);
    chk("div div_zero", 32'(u[0].dz), 0);
    go(0, 16'd9, 16'd0, 2'b11, 1'b0, lat);
    chk("div0 latency", lat, 1);
    chk("div0 o_lo", 32'(u[0].lo), 32'hFF);
    chk("div0 o_hi", 32'(u[0].hi), 32'h09);
    chk("div0 div_zero", 32'(u[0].dz), 1);
    wait_idle();
    ai = 16'd3;
    bi = 16'd5;
    opi = 2'b10;
    valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      pulses += int'(u[0].rdy);
      if (i == 11) valid = 1'b0;
    end
    chk("held valid ready pulses", pulses, 2);
    chk("held valid o_lo", 32'(u[0].lo), 32'h0F);
    wait_idle();
    ai = 16'd5;
    bi = 16'd3;
    opi = 2'b10;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort o_lo", 32'(u[0].lo), 0);
    chk("abort o_hi", 32'(u[0].hi), 0);
    chk("abort busy", 32'(u[0].bsy), 0);
    chk("abort ready", 32'(u[0].rdy), 0);
    pulses = 0;
    repeat (15) begin @(negedge clk); pulses += int'(u[0].rdy); end
    chk("abort no ready", pulses, 0);
    go(0, 16'd6, 16'd7, 2'b10, 1'b0, lat);
    chk("mul after abort o_hi", 32'(u[0].hi), 0);
    chk("mul after abort o_lo", 32'(u[0].lo), 32'h2A);
    go(1, 16'hFB2E, 16'h0237, 2'b10, 1'b0, lat);
    chk("w16 mul latency", lat, 18);
    chk("w16 mul o_hi", 32'(u[1].hi), 32'hFFF5);
    chk("w16 mul o_lo", 32'(u[1].lo), 32'h52E2);
    go(1, 16'hFFFF, 16'h0100, 2'b11, 1'b0, lat);
    chk("w16 div o_lo", 32'(u[1].lo), 32'h00FF);
    chk("w16 div o_hi", 32'(u[1].hi), 32'h00FF);
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = 16'h8080;
      if ($urandom_range(0, 7) == 0) rb = 16'h8080;
      go(0, ra, rb, 2'($urandom), 1'($urandom), lat);
    end
    repeat (25) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised successor to the team's 8-bit sequential ALU.
- Operand width is set by WIDTH; all four operations are multi-cycle and share one datapath: add, subtract, signed Booth multiply and unsigned restoring divide.
- Multiply returns the full 2*WIDTH product. Divide returns quotient and remainder.
- Adds overflow and divide-by-zero flags and an explicit busy output.
- Sits between the operand bus and the result consumer, under a valid/ready handshake.

Parameters:
- WIDTH, default 8: operand width in bits, minimum 4. The internal iteration counter is sized to clog2(WIDTH)+1 (local, not overridable).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- in  input  2*WIDTH  packed operands: A = in[2*WIDTH-1:WIDTH], B = in[WIDTH-1:0].
- op_codes  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- valid  input  1  request strobe; sampled only in IDLE.
- busy  output  1  high from the cycle after accept through the DONE cycle.
- ready  output  1  one-cycle pulse; results valid.
- o_lo  output  WIDTH  low result word.
- o_hi  output  WIDTH  high result word.
- overflow  output  1  signed overflow on add/sub.
- div_zero  output  1  divide by zero detected.

Behaviour:
- Reset (rst low at a rising edge):
  - state goes to IDLE; busy, ready, o_lo, o_hi, overflow and div_zero all go to 0; internal A/Q/M/Q[-1]/count are cleared.
  - Reset mid-operation aborts it: no ready pulse, and results stay 0.
- States: IDLE, ADDSUB, MUL, DIV, DONE.
- Accept:
  - In IDLE, valid=1 at edge E0 latches A, B and op_codes.
  - Next state: ADDSUB for 00/01, MUL for 10, DIV for 11 with B!=0, DONE for 11 with B==0.
  - valid while not in IDLE is ignored; it is not queued.
- ADDSUB: one cycle.
  - Computes A+B or A+~B+1, modulo 2^WIDTH, into o_lo, and sets o_hi=0.
  - overflow = signed two's-complement overflow.
  - Then goes to DONE.
- MUL: radix-2 Booth, A and B signed.
  - Setup at accept: Q=A, M=B, acc=0, Q[-1]=0.
  - Exactly WIDTH iterations, one per cycle. Each iteration applies add M / sub M / none according to {Q[0],Q[-1]}, then an arithmetic right shift of {acc,Q,Q[-1]}.
  - Result: o_hi=acc, o_lo=Q, which is the exact signed product; overflow=0.
  - The most-negative x most-negative case must be exact.
- DIV: unsigned restoring division, WIDTH iterations, one per cycle.
  - Each iteration: shift {R,Q} left, trial-subtract B, restore on negative, set Q[0].
  - Result: o_lo = quotient, o_hi = remainder, overflow = 0.
- Divide by zero (B==0, op 11):
  - No iterations are run.
  - Result: o_lo = all ones, o_hi = A, div_zero = 1.
- DONE: ready=1 for exactly this one cycle; busy stays 1. Next state is IDLE.
- Output registers:
  - o_lo, o_hi, overflow and div_zero update on the same edge that raises ready.
  - They hold until the next ready pulse or reset.
  - overflow and div_zero are cleared on every result update where they do not apply.
- Latency (accept edge E0 to the edge raising ready):
  - add/sub: 2 cycles.
  - mul: WIDTH+2 cycles.
  - div with B!=0: WIDTH+2 cycles.
  - div with B==0: 1 cycle.
- Back-to-back: the earliest next accept is the edge at which DONE goes to IDLE plus one cycle, i.e. valid sampled in IDLE.

Test Plan:
- WIDTH=8, add A=100, B=50:
  - ready 2 cycles after accept.
  - o_lo=0x96, o_hi=0x00, overflow=1.
  - Then sub A=5, B=7 gives o_lo=0xFE, overflow=0.
- WIDTH=8, mul A=-3 (0xFD), B=7:
  - ready exactly 10 cycles after accept.
  - o_hi=0xFF, o_lo=0xEB (-21).
  - Then mul 0x80 x 0x80 gives o_hi=0x40, o_lo=0x00.
- WIDTH=8, div A=200, B=7:
  - o_lo=0x1C, o_hi=0x04, div_zero=0, latency 10.
  - Then div A=9, B=0 gives o_lo=0xFF, o_hi=0x09, div_zero=1, latency 1.
- Handshake:
  - Hold valid high through a whole mul: only one ready pulse is produced per accept.
  - busy is high throughout; ready width is 1 cycle; the second accept occurs only in IDLE.
- Reset: drive rst low for one edge during MUL iteration 4.
  - Expect no ready, all outputs 0, state IDLE.
  - The next mul 6x7 gives o_hi=0x00, o_lo=0x2A.
- WIDTH=16, mul A=-1234, B=567:
  - {o_hi,o_lo}=0xFFF5_52E2 (-699678), latency 18.
  - Div 0xFFFF/0x0100 gives o_lo=0x00FF, o_hi=0x00FF.
